// File: rtl/uart_pkg.sv
// Shared UART definitions: default line settings, receiver state type and bit-period helper.
package uart_pkg;

  localparam int unsigned UART_CLK_FREQ = 50_000_000;
  localparam int unsigned UART_BAUD     = 115_200;
  localparam int unsigned UART_DATA_W   = 8;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} uart_rx_state_t;

  // Clocks per bit, rounded down.
  function automatic int unsigned bps_max(input int unsigned clk, input int unsigned baud);
    return clk / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial pin plus a delayed copy for falling-edge detection.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_async,
  output logic rx_s,
  output logic fall
);

  logic sync1_q, sync2_q, prev_q;

  // Reset to the idle-high line level so leaving reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_async;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rx_s = sync2_q;
  assign fall = prev_q & ~sync2_q;

endmodule

// File: rtl/uart_1byte_rx.sv
// 8N1 UART receiver: start-edge detection, mid-bit triple sampling with majority vote,
// one-cycle rx_done / frame_err strobes.
module uart_1byte_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = UART_CLK_FREQ,
  parameter int unsigned BAUD     = UART_BAUD
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   uart_rx,
  output logic [UART_DATA_W-1:0] rx_data,
  output logic                   rx_done,
  output logic                   frame_err,
  output logic                   rx_busy
);

  localparam int unsigned BPS_MAX = bps_max(CLK_FREQ, BAUD);
  localparam int unsigned MID     = BPS_MAX / 2;
  localparam int unsigned CNT_W   = $clog2(BPS_MAX);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(MID);
  localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(MID + 1);
  localparam logic [3:0]       IDX_LAST = 4'(UART_DATA_W);

  logic rx_s, fall;

  uart_rx_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .rx_async (uart_rx),
    .rx_s     (rx_s),
    .fall     (fall)
  );

  uart_rx_state_t         state_q;
  logic [CNT_W-1:0]       div_cnt_q;
  logic [3:0]             bit_idx_q;
  logic                   s0_q, s1_q;
  logic [UART_DATA_W-1:0] shreg_q;
  logic                   stop_ok_q;

  logic bit_val, cnt_wrap, decide;

  // The third sample is the live synchronized line at the decision count.
  assign bit_val  = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
  assign cnt_wrap = (div_cnt_q == CNT_LAST);
  assign decide   = (div_cnt_q == CNT_DEC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      div_cnt_q <= '0;
      bit_idx_q <= '0;
      s0_q      <= 1'b1;
      s1_q      <= 1'b1;
      shreg_q   <= '0;
      stop_ok_q <= 1'b0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;

      if (state_q inside {START, DATA, STOP}) begin
        if (cnt_wrap) begin
          div_cnt_q <= '0;
          bit_idx_q <= bit_idx_q + 4'd1;
        end else begin
          div_cnt_q <= div_cnt_q + 1'b1;
        end
        if (div_cnt_q == CNT_S0) s0_q <= rx_s;
        if (div_cnt_q == CNT_S1) s1_q <= rx_s;
      end

      unique case (state_q)
        IDLE: begin
          div_cnt_q <= '0;
          bit_idx_q <= '0;
          if (fall) begin
            state_q <= START;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (decide && bit_val) begin
            state_q <= IDLE;
            rx_busy <= 1'b0;
          end else if (cnt_wrap) begin
            state_q <= DATA;
          end
        end
        DATA: begin
          if (decide) shreg_q <= {bit_val, shreg_q[UART_DATA_W-1:1]};
          if (cnt_wrap && bit_idx_q == IDX_LAST) state_q <= STOP;
        end
        STOP: begin
          // Leave at mid-stop so a start edge half a bit later is still caught.
          if (decide) begin
            stop_ok_q <= bit_val;
            state_q   <= DONE;
          end
        end
        DONE: begin
          if (stop_ok_q) begin
            rx_data <= shreg_q;
            rx_done <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
          state_q <= IDLE;
          rx_busy <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
